perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Parametrised successor to the fixed two-counter performance monitor per core.
- Provides NUM_COUNTERS independent counters of COUNTER_WIDTH bits, each with a selectable source from NUM_EVENTS event strobes.
- Adds per-counter enable, sticky overflow with interrupt, global freeze, and tear-free 64-bit reads via a shadowed high half.
- Sits beside the control-register block in each core; the event vector comes from core_perf_events or the L2 event vector.

Parameters:
- NUM_EVENTS, 14, width of the event strobe input (CORE_PERF_EVENTS).
- NUM_COUNTERS, 4, number of counter slices (legal range 1..16).
- COUNTER_WIDTH, 48, counter bits (legal range 33..64).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- perf_events  in  NUM_EVENTS  one-cycle event strobes; more than one bit may be set at once.
- freeze  in  1  when 1, no counter increments.
- reg_write_en  in  1  register write strobe.
- reg_read_en  in  1  register read strobe; mutually exclusive with reg_write_en.
- reg_counter  in  $clog2(NUM_COUNTERS) (min 1)  target counter index.
- reg_field  in  2  target field, perf_reg_t: PR_SELECT=0, PR_COUNT_L=1, PR_COUNT_H=2, PR_CONTROL=3.
- reg_write_data  in  32  write value.
- reg_read_data  out  32  read value, valid the cycle after reg_read_en.
- overflow_irq  out  NUM_COUNTERS  level interrupt per counter, equal to overflow & irq_en.

Behaviour:
- Per-counter state: select[PERF_SEL_WIDTH-1:0], enable, irq_en, overflow (sticky), count[COUNTER_WIDTH-1:0], shadow_hi[COUNTER_WIDTH-33:0].
- Reset: all state is 0, reg_read_data=0, overflow_irq=0.
- Increment rule: a counter increments by 1 on a clock edge when enable=1 AND freeze=0 AND select<NUM_EVENTS AND perf_events[select]=1.
  - A select value >= NUM_EVENTS never counts and is not an error.
- Wrap: when count is all-ones and increments, count becomes 0 and overflow is set to 1 on the same edge. No saturation.
- Write PR_SELECT: select <= write_data[PERF_SEL_WIDTH-1:0]; upper bits are ignored.
- Write PR_COUNT_L: count[31:0] <= write_data.
- Write PR_COUNT_H: count[W-1:32] <= write_data[W-33:0].
- Write PR_CONTROL:
  - bit0 is enable, bit1 is irq_en; both are loaded.
  - bit2=1 clears overflow (write-one-to-clear); bit2=0 leaves overflow unchanged.
- Write/increment collision: a write to COUNT_L or COUNT_H of the incrementing counter wins on that cycle, and that increment is lost. A write to SELECT or CONTROL does not suppress the increment, which uses the pre-write select and enable.
- Overflow/clear collision: when a wrap and a CONTROL overflow-clear occur on the same edge, overflow ends at 1 (set wins).
- Read PR_COUNT_L: returns count[31:0] and, on the same edge, captures shadow_hi <= count[W-1:32] (pre-increment value).
- Read PR_COUNT_H: returns zero-extended shadow_hi, not the live high bits. Software reads L then H for a consistent snapshot.
- Read PR_SELECT: returns zero-extended select.
- Read PR_CONTROL: returns {29'b0, overflow, irq_en, enable}.
- Read latency: reg_read_data is registered, valid 1 cycle after reg_read_en, and holds its value until the next read.
- An out-of-range reg_counter (>= NUM_COUNTERS) writes nothing and reads 0.
- overflow_irq is registered from the state and updates the cycle after overflow changes.
- Reset asserted mid-operation clears everything immediately, including any pending read data.

Decomposition:
- Shared package (defines): PERF_SEL_WIDTH = $clog2(NUM_EVENTS) with a minimum of 1, perf_reg_t enum, and a typedef perf_control_t packed {overflow, irq_en, enable}.
- Sub-module perf_counter_slice holds one counter's state, increment, wrap, and shadow logic; it is instantiated NUM_COUNTERS times.
- The top level holds address decode and the read mux register.

Test Plan:
- Reset, then assert perf_events[3] for 10 cycles with counter 0 select=3 and enable=1 -> COUNT_L reads 10, COUNT_H reads 0, overflow_irq=0.
- Write count = 0xFFFF_FFFF_FFFE (W=48), irq_en=1, then 2 event pulses -> count=0, CONTROL reads 0x7, overflow_irq[0]=1 one cycle later; CONTROL write 0x7 -> overflow_irq[0]=0.
- Count=0x0000_FFFF_FFFF, read COUNT_L while an event increments -> returns 0xFFFF_FFFF; the later COUNT_H read returns 0x0 (shadow), not 0x1.
- Write COUNT_L=0x100 on the same cycle as a selected event -> next read of COUNT_L returns 0x100.
- freeze=1 with 5 events, then freeze=0 with 2 events -> count=2; select=15 (NUM_EVENTS=14) with perf_events all ones -> count unchanged.
- Counters 0 and 1 both select event 0 with one pulse -> each reads 1; reg_counter=7 with NUM_COUNTERS=4 -> reads 0 and writes have no effect.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared types and helpers for the per-core performance counter bank.
package perf_counter_bank_pkg;

   localparam int PERF_NUM_EVENTS = 14;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PERF_SEL_WIDTH = clog2_min1(PERF_NUM_EVENTS);

   typedef enum logic [1:0] {
      PR_SELECT  = 2'd0,
      PR_COUNT_L = 2'd1,
      PR_COUNT_H = 2'd2,
      PR_CONTROL = 2'd3
   } perf_reg_t;

   typedef struct packed {
      logic overflow;
      logic irq_en;
      logic enable;
   } perf_control_t;

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: event select, enable, increment with wrap, sticky
// overflow, interrupt level and the high-half shadow used for tear-free reads.
module perf_counter_slice
   import perf_counter_bank_pkg::*;
#(
   parameter int NUM_EVENTS    = PERF_NUM_EVENTS,
   parameter int COUNTER_WIDTH = 48
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_EVENTS-1:0]               i_events,
   input  logic                                i_freeze,
   input  logic                                i_wr_select,
   input  logic                                i_wr_count_l,
   input  logic                                i_wr_count_h,
   input  logic                                i_wr_control,
   input  logic                                i_rd_count_l,
   input  logic [31:0]                         i_wdata,
   output logic [clog2_min1(NUM_EVENTS)-1:0]   o_select,
   output logic [2:0]                          o_control,
   output logic [COUNTER_WIDTH-1:0]            o_count,
   output logic [COUNTER_WIDTH-33:0]           o_shadow_hi,
   output logic                                o_irq
);

   localparam int SEL_W = clog2_min1(NUM_EVENTS);
   localparam int HI_W  = COUNTER_WIDTH - 32;

   logic [SEL_W-1:0]         r_select;
   perf_control_t            r_control;
   logic [COUNTER_WIDTH-1:0] r_count;
   logic [HI_W-1:0]          r_shadow_hi;
   logic                     r_irq;
   logic                     w_event;
   logic                     w_inc;
   logic                     w_wrap;

   // Select values at or beyond NUM_EVENTS match no strobe and simply never count.
   always_comb begin
      w_event = 1'b0;  // NOTE: default assigned first so this block cannot infer a latch
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (r_select == SEL_W'(i)) w_event = i_events[i];
      end
   end

   // A software write to either count half takes the cycle; the increment is dropped.
   assign w_inc  = r_control.enable & ~i_freeze & w_event & ~(i_wr_count_l | i_wr_count_h);
   assign w_wrap = w_inc & (&r_count);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_select    <= '0;  // NOTE: state updated with non-blocking assignments only
         r_control   <= '0;
         r_count     <= '0;
         r_shadow_hi <= '0;
         r_irq       <= 1'b0;
      end else begin
         if (i_wr_select) r_select <= i_wdata[SEL_W-1:0];

         if (i_wr_count_l)      r_count[31:0]              <= i_wdata;
         else if (i_wr_count_h) r_count[COUNTER_WIDTH-1:32] <= i_wdata[HI_W-1:0];
         else if (w_inc)        r_count                     <= r_count + COUNTER_WIDTH'(1);

         if (i_wr_control) begin
            r_control.enable <= i_wdata[0];
            r_control.irq_en <= i_wdata[1];
         end
         // A wrap on the same edge as a write-one-to-clear keeps the flag set.
         if (w_wrap)                          r_control.overflow <= 1'b1;
         else if (i_wr_control && i_wdata[2]) r_control.overflow <= 1'b0;

         if (i_rd_count_l) r_shadow_hi <= r_count[COUNTER_WIDTH-1:32];

         r_irq <= r_control.overflow & r_control.irq_en;
      end
   end

   assign o_select    = r_select;
   assign o_control   = r_control;
   assign o_count     = r_count;
   assign o_shadow_hi = r_shadow_hi;
   assign o_irq       = r_irq;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_COUNTERS event counters with register decode and a registered
// read port; reading COUNT_L snapshots the high half for a following COUNT_H read.
module perf_counter_bank
   import perf_counter_bank_pkg::*;
#(
   parameter int NUM_EVENTS    = PERF_NUM_EVENTS,
   parameter int NUM_COUNTERS  = 4,
   parameter int COUNTER_WIDTH = 48
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_EVENTS-1:0]                perf_events,
   input  logic                                 freeze,
   input  logic                                 reg_write_en,
   input  logic                                 reg_read_en,
   input  logic [clog2_min1(NUM_COUNTERS)-1:0]  reg_counter,
   input  logic [1:0]                           reg_field,
   input  logic [31:0]                          reg_write_data,
   output logic [31:0]                          reg_read_data,
   output logic [NUM_COUNTERS-1:0]              overflow_irq
);

   localparam int SEL_W = clog2_min1(NUM_EVENTS);
   localparam int HI_W  = COUNTER_WIDTH - 32;

   logic                     w_in_range;
   logic [NUM_COUNTERS-1:0]  w_hit;
   logic [SEL_W-1:0]         w_select    [NUM_COUNTERS];
   logic [2:0]               w_control   [NUM_COUNTERS];
   logic [COUNTER_WIDTH-1:0] w_count     [NUM_COUNTERS];
   logic [HI_W-1:0]          w_shadow_hi [NUM_COUNTERS];
   logic [31:0]              w_rd_value;
   logic [31:0]              r_read_data;

   // Out-of-range indices hit no slice, so they write nothing and read zero.
   assign w_in_range = int'(reg_counter) < NUM_COUNTERS;

   for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slice
      assign w_hit[g] = w_in_range && (int'(reg_counter) == g);

      perf_counter_slice #(
         .NUM_EVENTS    (NUM_EVENTS),
         .COUNTER_WIDTH (COUNTER_WIDTH)
      ) u_slice (
         .clk          (clk),
         .reset_n      (reset_n),
         .i_events     (perf_events),
         .i_freeze     (freeze),
         .i_wr_select  (reg_write_en && w_hit[g] && (reg_field == PR_SELECT)),
         .i_wr_count_l (reg_write_en && w_hit[g] && (reg_field == PR_COUNT_L)),
         .i_wr_count_h (reg_write_en && w_hit[g] && (reg_field == PR_COUNT_H)),
         .i_wr_control (reg_write_en && w_hit[g] && (reg_field == PR_CONTROL)),
         .i_rd_count_l (reg_read_en  && w_hit[g] && (reg_field == PR_COUNT_L)),
         .i_wdata      (reg_write_data),
         .o_select     (w_select[g]),
         .o_control    (w_control[g]),
         .o_count      (w_count[g]),
         .o_shadow_hi  (w_shadow_hi[g]),
         .o_irq        (overflow_irq[g])
      );
   end

   always_comb begin
      w_rd_value = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (w_hit[i]) begin
            case (perf_reg_t'(reg_field))
               PR_SELECT:  w_rd_value = 32'(w_select[i]);
               PR_COUNT_L: w_rd_value = w_count[i][31:0];
               PR_COUNT_H: w_rd_value = 32'(w_shadow_hi[i]);
               PR_CONTROL: w_rd_value = 32'(w_control[i]);
               default:    w_rd_value = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         r_read_data <= '0;
      else if (reg_read_en) r_read_data <= w_rd_value;
   end

   assign reg_read_data = r_read_data;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: stimulus pushes expected read data,
// a monitor pops and compares whenever the registered read data becomes valid.
module tb_perf_counter_bank;
   import perf_counter_bank_pkg::*;

   localparam int NE = 14;
   localparam int W  = 48;
   localparam int CW = 2;
   localparam logic [NE-1:0] EV0 = NE'(1);
   localparam logic [NE-1:0] EV3 = NE'(8);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NE-1:0] perf_events = '0;
   logic          freeze = 1'b0;
   logic          reg_write_en = 1'b0;
   logic          reg_read_en = 1'b0;
   logic [CW-1:0] reg_counter = '0;
   logic [1:0]    reg_field = '0;
   logic [31:0]   reg_write_data = '0;
   logic [31:0]   reg_read_data;
   logic [3:0]    overflow_irq;
   logic [31:0]   reg_read_data_b;
   logic [2:0]    overflow_irq_b;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(4), .COUNTER_WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .perf_events(perf_events), .freeze(freeze),
      .reg_write_en(reg_write_en), .reg_read_en(reg_read_en), .reg_counter(reg_counter),
      .reg_field(reg_field), .reg_write_data(reg_write_data),
      .reg_read_data(reg_read_data), .overflow_irq(overflow_irq)
   );

   // Three-counter instance on the same stimulus: index 3 is out of range here.
   perf_counter_bank #(.NUM_EVENTS(NE), .NUM_COUNTERS(3), .COUNTER_WIDTH(W)) dut_b (
      .clk(clk), .reset_n(reset_n), .perf_events(perf_events), .freeze(freeze),
      .reg_write_en(reg_write_en), .reg_read_en(reg_read_en), .reg_counter(reg_counter),
      .reg_field(reg_field), .reg_write_data(reg_write_data),
      .reg_read_data(reg_read_data_b), .overflow_irq(overflow_irq_b)
   );

   typedef struct {
      string       name;
      logic [31:0] exp;
      bit          chk_b;
      logic [31:0] exp_b;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a read accepted on a rising edge is compared on the following falling edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (reset_n && reg_read_en) begin
            @(negedge clk);
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_read: got 0x%08h with empty scoreboard", reg_read_data);
            end else begin
               e = sb.pop_front();
               check(e.name, reg_read_data, e.exp);
               if (e.chk_b) check({e.name, "_b"}, reg_read_data_b, e.exp_b);
            end
         end
      end
   end

   // Drive one cycle of register/event activity starting at a falling edge.
   task automatic op(input bit we, input bit re, input int cnt, input perf_reg_t f,
                     input logic [31:0] wd, input logic [NE-1:0] ev);
      reg_write_en   = we;
      reg_read_en    = re;
      reg_counter    = CW'(cnt);
      reg_field      = f;
      reg_write_data = wd;
      perf_events    = ev;
      @(negedge clk);
      reg_write_en = 1'b0;
      reg_read_en  = 1'b0;
      perf_events  = '0;
   endtask

   task automatic wr(input int cnt, input perf_reg_t f, input logic [31:0] wd,
                     input logic [NE-1:0] ev = '0);
      op(1'b1, 1'b0, cnt, f, wd, ev);
   endtask

   task automatic rd2(input string name, input int cnt, input perf_reg_t f,
                      input logic [31:0] exp, input bit chk_b, input logic [31:0] exp_b,
                      input logic [NE-1:0] ev = '0);
      exp_t e;
      e.name  = name;
      e.exp   = exp;
      e.chk_b = chk_b;
      e.exp_b = exp_b;
      sb.push_back(e);
      op(1'b0, 1'b1, cnt, f, 32'h0, ev);
   endtask

   task automatic rd(input string name, input int cnt, input perf_reg_t f,
                     input logic [31:0] exp, input logic [NE-1:0] ev = '0);
      rd2(name, cnt, f, exp, 1'b0, 32'h0, ev);
   endtask

   task automatic pulse(input logic [NE-1:0] ev);
      op(1'b0, 1'b0, 0, PR_SELECT, 32'h0, ev);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d reads never returned, expected 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_read_data", reg_read_data, 32'h0);
      check("reset_irq", 32'(overflow_irq), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic counting on event 3.
      rd("reset_control", 0, PR_CONTROL, 32'h0);
      wr(0, PR_SELECT, 32'd3);
      wr(0, PR_CONTROL, 32'h1);
      perf_events = EV3;
      repeat (10) @(negedge clk);
      perf_events = '0;
      rd("count10_l", 0, PR_COUNT_L, 32'd10);
      rd("count10_h", 0, PR_COUNT_H, 32'd0);
      check("count10_irq", 32'(overflow_irq), 32'h0);

      // Wrap sets overflow; interrupt follows one cycle later; W1C clears it.
      wr(0, PR_COUNT_L, 32'hFFFF_FFFE);
      wr(0, PR_COUNT_H, 32'h0000_FFFF);
      wr(0, PR_CONTROL, 32'h3);
      pulse(EV3);
      pulse(EV3);
      check("wrap_irq_not_yet", 32'(overflow_irq), 32'h0);
      @(negedge clk);
      check("wrap_irq_set", 32'(overflow_irq), 32'h1);
      rd("wrap_count_l", 0, PR_COUNT_L, 32'h0);
      rd("wrap_count_h", 0, PR_COUNT_H, 32'h0);
      rd("wrap_control", 0, PR_CONTROL, 32'h7);
      wr(0, PR_CONTROL, 32'h7);
      @(negedge clk);
      check("w1c_irq_clear", 32'(overflow_irq), 32'h0);
      rd("w1c_control", 0, PR_CONTROL, 32'h3);

      // Shadowed high half: COUNT_H returns the value captured by the COUNT_L read.
      wr(0, PR_COUNT_H, 32'h0);
      wr(0, PR_COUNT_L, 32'hFFFF_FFFF);
      rd("tear_l", 0, PR_COUNT_L, 32'hFFFF_FFFF, EV3);
      rd("tear_h_shadow", 0, PR_COUNT_H, 32'h0);
      rd("tear_l2", 0, PR_COUNT_L, 32'h0);
      rd("tear_h2", 0, PR_COUNT_H, 32'h1);

      // A count write wins over a simultaneous increment.
      op(1'b1, 1'b0, 0, PR_COUNT_L, 32'h100, EV3);
      rd("wr_wins_l", 0, PR_COUNT_L, 32'h100);

      // Freeze and out-of-range select.
      wr(0, PR_COUNT_L, 32'h0);
      wr(0, PR_COUNT_H, 32'h0);
      freeze = 1'b1;
      repeat (5) pulse(EV3);
      freeze = 1'b0;
      repeat (2) pulse(EV3);
      rd("freeze_count", 0, PR_COUNT_L, 32'd2);
      wr(0, PR_SELECT, 32'd15);
      repeat (3) pulse('1);
      rd("sel15_count", 0, PR_COUNT_L, 32'd2);
      rd("sel15_read", 0, PR_SELECT, 32'd15);
      wr(0, PR_SELECT, 32'h35);
      rd("sel_upper_ignored", 0, PR_SELECT, 32'd5);

      // Two counters sharing one event source.
      wr(0, PR_SELECT, 32'd0);
      wr(0, PR_COUNT_L, 32'h0);
      wr(1, PR_SELECT, 32'd0);
      wr(1, PR_CONTROL, 32'h1);
      pulse(EV0);
      rd("shared_c0", 0, PR_COUNT_L, 32'd1);
      rd("shared_c1", 1, PR_COUNT_L, 32'd1);

      // Index 3: valid on the four-counter bank, out of range on the three-counter one.
      wr(3, PR_COUNT_L, 32'h55);
      wr(3, PR_CONTROL, 32'h3);
      rd2("oor_count", 3, PR_COUNT_L, 32'h55, 1'b1, 32'h0);
      rd2("oor_control", 3, PR_CONTROL, 32'h3, 1'b1, 32'h0);
      rd2("inrange_c0", 0, PR_COUNT_L, 32'd1, 1'b1, 32'd1);
      rd2("untouched_c2", 2, PR_COUNT_L, 32'd0, 1'b1, 32'd0);

      // Wrap and overflow clear on the same edge: set wins; control write keeps the old enable.
      wr(0, PR_COUNT_H, 32'h0000_FFFF);
      wr(0, PR_COUNT_L, 32'hFFFF_FFFF);
      op(1'b1, 1'b0, 0, PR_CONTROL, 32'h7, EV0);
      rd("set_wins_control", 0, PR_CONTROL, 32'h7);
      op(1'b1, 1'b0, 0, PR_CONTROL, 32'h4, EV0);
      rd("old_enable_count", 0, PR_COUNT_L, 32'd1);
      rd("disabled_control", 0, PR_CONTROL, 32'h0);
      pulse(EV0);
      rd("disabled_count", 0, PR_COUNT_L, 32'd1);

      // Read data holds, then an asynchronous reset clears it at once.
      drain();
      @(negedge clk);
      check("read_data_hold", reg_read_data, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_read_data", reg_read_data, 32'h0);
      check("async_reset_irq", 32'(overflow_irq), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd("post_reset_count", 0, PR_COUNT_L, 32'h0);
      rd("post_reset_control", 1, PR_CONTROL, 32'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
